// File: rtl/mandel_pkg.sv
// Shared fixed-point types, key indices and saturating arithmetic for the
// Mandelbrot view controller.
package mandel_pkg;

   localparam int FRAC   = 10;
   localparam int INT    = 10;
   localparam int WIDTH  = FRAC + INT;
   localparam int PIX_W  = 10;
   localparam int ZOOM_W = 5;

   typedef logic signed [WIDTH-1:0] fx_t;

   localparam int KEY_RIGHT = 0;
   localparam int KEY_UP    = 1;
   localparam int KEY_DOWN  = 2;
   localparam int KEY_LEFT  = 3;
   localparam int KEY_ZIN   = 4;
   localparam int KEY_ZOUT  = 5;

   localparam fx_t FX_MAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam fx_t FX_MIN = {1'b1, {(WIDTH-1){1'b0}}};

   // One guard bit detects overflow; clamp to the signed limit instead of wrapping
   function automatic fx_t sat_add(input fx_t a, input fx_t b);
      logic signed [WIDTH:0] sum;
      sum = {a[WIDTH-1], a} + {b[WIDTH-1], b};
      if (sum[WIDTH] != sum[WIDTH-1]) begin
         return sum[WIDTH] ? FX_MIN : FX_MAX;
      end else begin
         return sum[WIDTH-1:0];
      end
   endfunction

endpackage

// File: rtl/mandel_view_ctrl_if.sv
// Pixel/key inputs and complex-coordinate outputs of the view controller.
interface mandel_view_ctrl_if;
   import mandel_pkg::*;

   logic              frame_start;
   logic              pix_valid;
   logic [PIX_W-1:0]  x_in;
   logic [PIX_W-1:0]  y_in;
   logic [5:0]        keys;
   fx_t               c_real;
   fx_t               c_imag;
   logic              c_valid;
   logic [PIX_W-1:0]  x_out;
   logic [PIX_W-1:0]  y_out;
   logic [ZOOM_W-1:0] zoom_level;

   modport master (
      output frame_start, pix_valid, x_in, y_in, keys,
      input  c_real, c_imag, c_valid, x_out, y_out, zoom_level
   );

   modport slave (
      input  frame_start, pix_valid, x_in, y_in, keys,
      output c_real, c_imag, c_valid, x_out, y_out, zoom_level
   );

endinterface

// File: rtl/view_key_tick.sv
// Auto-repeat tick divider and key sampler: one-cycle pan/zoom strobes per tick,
// with opposing keys cancelling each other.
module view_key_tick
   import mandel_pkg::*;
#(
   parameter int TICK_DIV = 256
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] i_keys_n,
   output logic       o_right,
   output logic       o_left,
   output logic       o_down,
   output logic       o_up,
   output logic       o_zin,
   output logic       o_zout
);

   localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [CNT_W-1:0] r_cnt;
   logic [5:0]       r_keys;
   logic             w_tick;

   assign w_tick = (r_cnt == CNT_W'(TICK_DIV - 1));

   // Keys are registered (active-high) before sampling to keep them off async paths
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt  <= '0;
         r_keys <= '0;
      end else begin
         r_cnt  <= w_tick ? '0 : r_cnt + CNT_W'(1);
         r_keys <= ~i_keys_n;
      end
   end

   assign o_right = w_tick &  r_keys[KEY_RIGHT] & ~r_keys[KEY_LEFT];
   assign o_left  = w_tick &  r_keys[KEY_LEFT]  & ~r_keys[KEY_RIGHT];
   assign o_down  = w_tick &  r_keys[KEY_DOWN]  & ~r_keys[KEY_UP];
   assign o_up    = w_tick &  r_keys[KEY_UP]    & ~r_keys[KEY_DOWN];
   assign o_zin   = w_tick &  r_keys[KEY_ZIN]   & ~r_keys[KEY_ZOUT];
   assign o_zout  = w_tick &  r_keys[KEY_ZOUT]  & ~r_keys[KEY_ZIN];

endmodule

// File: rtl/mandel_view_ctrl.sv
// Pixel-to-complex mapper: key-driven pending view, frame-start commit to the
// active view, and a 2-stage shift-based coordinate pipeline.
module mandel_view_ctrl
   import mandel_pkg::*;
#(
   parameter int H_CENTER   = 320,
   parameter int V_CENTER   = 240,
   parameter int BASE_SHIFT = 8,
   parameter int ZOOM_MAX   = 15,
   parameter int PAN_PIX    = 4,
   parameter int TICK_DIV   = 256,
   parameter int INIT_CX    = -512,
   parameter int INIT_CY    = 0,
   parameter int INIT_ZOOM  = 0
) (
   input logic               clk,
   input logic               rst,
   mandel_view_ctrl_if.slave bus
);

   localparam int  D_W    = PIX_W + 1;
   localparam int  O_W    = D_W + FRAC;
   localparam fx_t PAN_FX = fx_t'(PAN_PIX <<< FRAC);

   logic                  w_right, w_left, w_down, w_up, w_zin, w_zout;
   fx_t                   r_pcx, r_pcy, r_acx, r_acy;
   fx_t                   w_pcx_nx, w_pcy_nx, w_dc;
   logic [ZOOM_W-1:0]     r_pzoom, r_azoom, w_pzoom_nx;
   logic                  r_v1;
   logic [PIX_W-1:0]      r_x1, r_y1;
   logic signed [D_W-1:0] r_dx, r_dy;
   logic signed [O_W-1:0] w_offx, w_offy;
   fx_t                   r_creal, r_cimag;
   logic                  r_cvalid;
   logic [PIX_W-1:0]      r_xout, r_yout;

   view_key_tick #(.TICK_DIV(TICK_DIV)) u_keys (
      .clk      (clk),
      .rst      (rst),
      .i_keys_n (bus.keys),
      .o_right  (w_right),
      .o_left   (w_left),
      .o_down   (w_down),
      .o_up     (w_up),
      .o_zin    (w_zin),
      .o_zout   (w_zout)
   );

   // Pan step is one PAN_PIX screen move at the pending (pre-update) zoom
   assign w_dc = PAN_FX >>> (BASE_SHIFT + int'(r_pzoom));

   always_comb begin
      w_pcx_nx   = r_pcx;
      w_pcy_nx   = r_pcy;
      w_pzoom_nx = r_pzoom;
      if (w_right) begin
         w_pcx_nx = sat_add(r_pcx, w_dc);
      end else if (w_left) begin
         w_pcx_nx = sat_add(r_pcx, -w_dc);
      end else begin
         w_pcx_nx = r_pcx;
      end
      if (w_down) begin
         w_pcy_nx = sat_add(r_pcy, w_dc);
      end else if (w_up) begin
         w_pcy_nx = sat_add(r_pcy, -w_dc);
      end else begin
         w_pcy_nx = r_pcy;
      end
      if (w_zin && (r_pzoom != ZOOM_W'(ZOOM_MAX))) begin
         w_pzoom_nx = r_pzoom + ZOOM_W'(1);
      end else if (w_zout && (r_pzoom != '0)) begin
         w_pzoom_nx = r_pzoom - ZOOM_W'(1);
      end else begin
         w_pzoom_nx = r_pzoom;
      end
   end

   // Commit copies the pre-tick pending view, so a same-cycle tick lands next frame
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pcx   <= fx_t'(INIT_CX);
         r_pcy   <= fx_t'(INIT_CY);
         r_pzoom <= ZOOM_W'(INIT_ZOOM);
         r_acx   <= fx_t'(INIT_CX);
         r_acy   <= fx_t'(INIT_CY);
         r_azoom <= ZOOM_W'(INIT_ZOOM);
      end else begin
         r_pcx   <= w_pcx_nx;
         r_pcy   <= w_pcy_nx;
         r_pzoom <= w_pzoom_nx;
         if (bus.frame_start) begin
            r_acx   <= r_pcx;
            r_acy   <= r_pcy;
            r_azoom <= r_pzoom;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_v1 <= 1'b0;
         r_x1 <= '0;
         r_y1 <= '0;
         r_dx <= '0;
         r_dy <= '0;
      end else begin
         r_v1 <= bus.pix_valid;
         r_x1 <= bus.x_in;
         r_y1 <= bus.y_in;
         r_dx <= $signed({1'b0, bus.x_in}) - D_W'(H_CENTER);
         r_dy <= $signed({1'b0, bus.y_in}) - D_W'(V_CENTER);
      end
   end

   assign w_offx = ($signed(O_W'(r_dx)) <<< FRAC) >>> (BASE_SHIFT + int'(r_azoom));
   assign w_offy = ($signed(O_W'(r_dy)) <<< FRAC) >>> (BASE_SHIFT + int'(r_azoom));

   // Outputs hold their last valid pixel while the pipeline carries bubbles
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cvalid <= 1'b0;
         r_creal  <= '0;
         r_cimag  <= '0;
         r_xout   <= '0;
         r_yout   <= '0;
      end else begin
         r_cvalid <= r_v1;
         if (r_v1) begin
            r_creal <= sat_add(r_acx, fx_t'(w_offx));
            r_cimag <= sat_add(r_acy, fx_t'(w_offy));
            r_xout  <= r_x1;
            r_yout  <= r_y1;
         end
      end
   end

   assign bus.c_real     = r_creal;
   assign bus.c_imag     = r_cimag;
   assign bus.c_valid    = r_cvalid;
   assign bus.x_out      = r_xout;
   assign bus.y_out      = r_yout;
   assign bus.zoom_level = r_azoom;

endmodule

// File: tb/tb_mandel_view_ctrl.sv
// Directed bench for mandel_view_ctrl: a pixel vector table plus hand-written
// key/commit/reset sequences; a second instance exercises center saturation.
module tb_mandel_view_ctrl;
   import mandel_pkg::*;

   localparam int TD       = 256;
   localparam int TD_SAT   = 16;
   localparam int SAT_INIT = 524287 - 100;
   localparam int NV       = 6;

   typedef struct packed {
      int x;
      int y;
      int er;
      int ei;
   } vec_t;

   logic              clk = 1'b0;
   logic              rst;
   logic              sel;
   logic              frame_start;
   logic              pix_valid;
   logic [PIX_W-1:0]  x_in;
   logic [PIX_W-1:0]  y_in;
   logic [5:0]        keys;
   fx_t               c_real;
   fx_t               c_imag;
   logic              c_valid;
   logic [PIX_W-1:0]  x_out;
   logic [PIX_W-1:0]  y_out;
   logic [ZOOM_W-1:0] zoom_level;
   int                ncyc;
   int                n_vec;
   int                n_err;
   vec_t              tbl [NV];

   always #5 clk = ~clk;

   mandel_view_ctrl_if m_if ();
   mandel_view_ctrl_if s_if ();

   assign m_if.frame_start = frame_start;
   assign m_if.pix_valid   = pix_valid;
   assign m_if.x_in        = x_in;
   assign m_if.y_in        = y_in;
   assign m_if.keys        = sel ? 6'h3F : keys;
   assign s_if.frame_start = frame_start;
   assign s_if.pix_valid   = pix_valid;
   assign s_if.x_in        = x_in;
   assign s_if.y_in        = y_in;
   assign s_if.keys        = sel ? keys : 6'h3F;

   assign c_real     = sel ? s_if.c_real     : m_if.c_real;
   assign c_imag     = sel ? s_if.c_imag     : m_if.c_imag;
   assign c_valid    = sel ? s_if.c_valid    : m_if.c_valid;
   assign x_out      = sel ? s_if.x_out      : m_if.x_out;
   assign y_out      = sel ? s_if.y_out      : m_if.y_out;
   assign zoom_level = sel ? s_if.zoom_level : m_if.zoom_level;

   mandel_view_ctrl #(.TICK_DIV(TD)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (m_if.slave)
   );

   mandel_view_ctrl #(.TICK_DIV(TD_SAT), .INIT_CX(SAT_INIT)) u_sat (
      .clk (clk),
      .rst (rst),
      .bus (s_if.slave)
   );

   // Edges since reset release; main-instance ticks fall on edges where this is a multiple of TD
   always @(posedge clk or posedge rst) begin
      if (rst) ncyc <= 0;
      else     ncyc <= ncyc + 1;
   end

   task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic probe(input string name, input int px, input int py, input int er, input int ei);
      @(negedge clk);
      pix_valid = 1'b1;
      x_in      = PIX_W'(px);
      y_in      = PIX_W'(py);
      @(negedge clk);
      pix_valid = 1'b0;
      @(negedge clk);
      chk({name, " c_valid"}, c_valid, 1);
      chk({name, " c_real"}, c_real, er);
      chk({name, " c_imag"}, c_imag, ei);
      @(negedge clk);
      chk({name, " hold valid"}, c_valid, 0);
      chk({name, " hold real"}, c_real, er);
   endtask

   task automatic hold_keys(input logic [5:0] k, input int nticks, input int td);
      @(negedge clk);
      keys = k;
      repeat (nticks * td) @(negedge clk);
      keys = 6'h3F;
   endtask

   task automatic commit();
      @(negedge clk);
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: run did not reach the summary");
      $fatal(1);
   end

   initial begin
      n_vec = 0;
      n_err = 0;
      rst = 1'b1; sel = 1'b0; frame_start = 1'b0; pix_valid = 1'b0;
      x_in = '0; y_in = '0; keys = 6'h3F;
      tbl[0] = '{320, 240, -512, 0};
      tbl[1] = '{576, 240, 512, 0};
      tbl[2] = '{0, 0, -1792, -960};
      tbl[3] = '{639, 479, 764, 956};
      tbl[4] = '{321, 239, -508, -4};
      tbl[5] = '{1023, 1023, 2300, 3132};

      repeat (3) @(negedge clk);
      chk("reset c_valid", c_valid, 0);
      chk("reset c_real", c_real, 0);
      chk("reset c_imag", c_imag, 0);
      chk("reset x_out", x_out, 0);
      chk("reset y_out", y_out, 0);
      chk("reset zoom", zoom_level, 0);
      rst = 1'b0;

      // Back-to-back pixels, one per clock, checked two clocks after entry
      @(negedge clk);
      for (int i = 0; i < NV + 2; i++) begin
         if (i >= 2) begin
            chk($sformatf("vec%0d c_valid", i - 2), c_valid, 1);
            chk($sformatf("vec%0d c_real", i - 2), c_real, tbl[i-2].er);
            chk($sformatf("vec%0d c_imag", i - 2), c_imag, tbl[i-2].ei);
            chk($sformatf("vec%0d x_out", i - 2), x_out, tbl[i-2].x);
            chk($sformatf("vec%0d y_out", i - 2), y_out, tbl[i-2].y);
         end
         if (i < NV) begin
            pix_valid = 1'b1;
            x_in      = PIX_W'(tbl[i].x);
            y_in      = PIX_W'(tbl[i].y);
         end else begin
            pix_valid = 1'b0;
         end
         @(negedge clk);
      end
      chk("stream end c_valid", c_valid, 0);
      chk("stream end hold", c_real, tbl[NV-1].er);

      hold_keys(6'b111110, 1, TD);
      probe("right uncommitted", 320, 240, -512, 0);
      commit();
      probe("right committed", 320, 240, -496, 0);

      hold_keys(6'b110001, 1, TD);
      commit();
      probe("left, up+down cancel", 320, 240, -512, 0);

      hold_keys(6'b110100, 1, TD);
      commit();
      probe("right+left cancel, up", 320, 240, -512, -16);

      hold_keys(6'b101111, 2, TD);
      chk("zoom pending only", zoom_level, 0);
      probe("zoom uncommitted", 576, 240, 512, -16);
      commit();
      chk("zoom 2 committed", zoom_level, 2);
      probe("zoom 2 pixel", 576, 240, -256, -16);

      hold_keys(6'b001111, 1, TD);
      commit();
      chk("zoom in+out cancel", zoom_level, 2);

      hold_keys(6'b111110, 1, TD);
      commit();
      probe("right at zoom 2", 320, 240, -508, -16);

      hold_keys(6'b011111, 3, TD);
      commit();
      chk("zoom out floor", zoom_level, 0);

      hold_keys(6'b101110, 1, TD);
      commit();
      chk("pan+zoom zoom", zoom_level, 1);
      probe("pan+zoom uses old zoom", 576, 240, 20, -16);

      // Commit on the tick edge itself must capture the pre-tick view
      while ((ncyc % TD) != TD - 4) @(negedge clk);
      keys = 6'b111110;
      while ((ncyc % TD) != TD - 1) @(negedge clk);
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
      keys        = 6'h3F;
      probe("commit on tick old view", 320, 240, -492, -16);
      commit();
      probe("next commit new view", 320, 240, -484, -16);

      hold_keys(6'b101111, 20, TD);
      commit();
      chk("zoom ceiling", zoom_level, 15);
      probe("zoom 15 centre", 576, 240, -484, -16);
      probe("zoom 15 floor shift", 0, 0, -485, -17);

      @(negedge clk);
      pix_valid = 1'b1;
      x_in      = PIX_W'(320);
      y_in      = PIX_W'(240);
      @(negedge clk);
      @(negedge clk);
      chk("pre-reset c_valid", c_valid, 1);
      rst = 1'b1;
      #1;
      chk("async reset c_valid", c_valid, 0);
      chk("async reset c_real", c_real, 0);
      chk("async reset zoom", zoom_level, 0);
      @(negedge clk);
      rst       = 1'b0;
      pix_valid = 1'b0;
      probe("after reset view", 320, 240, -512, 0);

      @(negedge clk);
      sel = 1'b1;
      hold_keys(6'b111110, 10, TD_SAT);
      probe("sat uncommitted", 320, 240, SAT_INIT, 0);
      probe("sat datapath clamp", 576, 240, 524287, 0);
      commit();
      probe("sat centre clamp", 320, 240, 524287, 0);
      probe("sat centre minus offset", 0, 240, 524287 - 1280, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
